sdf_bitrev_reorder: RTL and testbench
=====================================

// Module: sdf_bitrev_reorder
// PURPOSE
//  Natural-order output reorder buffer for the radix-2 SDF FFT pipeline. Consumes the
//  bit-reversed sample stream from the last SDF stage (same di_en/di_re/di_im protocol)
//  and re-emits each N-point frame in natural frequency order on the do_en/do_re/do_im
//  protocol. Ping-pong double buffer: one bank fills while the other drains.
// PARAMETERS
//  LOG_N   6    log2 of FFT length; N = 2**LOG_N samples per frame (LOG_N >= 2)
//  WIDTH   16   data bit length per real/imag component
// PORTS
//  clock   in   1      master clock; all logic on posedge
//  reset   in   1      synchronous, active-high reset
//  di_en   in   1      input sample valid; gaps between samples allowed
//  di_re   in   WIDTH  input data (real), bit-reversed frame order
//  di_im   in   WIDTH  input data (imag), bit-reversed frame order
//  do_en   out  1      output sample valid; high for N contiguous cycles per frame
//  do_re   out  WIDTH  output data (real), natural order
//  do_im   out  WIDTH  output data (imag), natural order
// BEHAVIOUR
//  - Reset (sync): do_en=0, do_re=0, do_im=0, wcnt=0, wbank=0, rbank=0, full[1:0]=0,
//    read FSM=IDLE. RAM contents not cleared. Reset mid-frame discards the partial
//    frame and any pending or draining frame. do_en is 0 in the cycle after reset is
//    sampled.
//  - Storage: 2 banks x N words x 2*WIDTH bits (re/im). Synchronous write, registered read.
//  - Write side: each sampled di_en writes {di_re,di_im} to bank wbank at address
//    bitrev(wcnt) over LOG_N bits, then wcnt++. On the write with wcnt==N-1: wcnt wraps
//    to 0, full[wbank] is set, and wbank toggles.
//  - A frame is counted only by di_en samples. No frame timeout.
//  - Read FSM:
//    - IDLE: if full[rbank], go to READ with raddr=0.
//    - READ: issue raddr each cycle and increment it.
//    - When raddr==N-1 is issued: clear full[rbank] and toggle rbank. If full of the
//      other bank is set (or is being set this cycle), stay in READ with raddr=0, giving
//      a back-to-back frame with no bubble. Otherwise go to IDLE.
//  - Output pipeline: RAM read data is registered into do_re/do_im, with do_en aligned.
//    The first do_en of a frame occurs exactly 2 cycles after the cycle in which the
//    frame's last di_en is sampled. do_en then stays high for exactly N cycles.
//  - do_re/do_im hold their last value while do_en=0. Downstream must not sample them
//    when do_en=0.
//  - Throughput: sustains continuous di_en (1 sample/cycle) indefinitely. Writing bank b
//    cannot begin before bank b has drained, because a frame fill takes >= N cycles
//    while a drain takes exactly N cycles. No backpressure, so no overflow case exists.
//  - Simultaneous full-set and full-clear on different banks in the same cycle: both
//    take effect.
//  - No arithmetic. Data passes bit-exact; re and im are independent.
// TESTING  (LOG_N=3, N=8, WIDTH=16 unless stated)
//  1. One frame, di_en continuous, di_re=i, di_im=100+i for i=0..7 ->
//     do_re = 0,4,2,6,1,5,3,7 and do_im = 100 + the same order; first do_en 2 cycles
//     after the last di_en.
//  2. Three frames back-to-back, continuous di_en for 24 cycles -> do_en high for 24
//     contiguous cycles, each frame correctly reordered, no bubbles.
//  3. One frame with di_en high every other cycle (i=0..7) -> same output order as test 1;
//     do_en is a contiguous 8-cycle burst.
//  4. Reset asserted after 5 samples of a frame, then a full new frame i=10..17 ->
//     only the new frame is output, as 10,14,12,16,11,15,13,17; do_en=0 before it.
//  5. Reset asserted during a drain (3rd do_en cycle) -> do_en=0 and do_re=do_im=0 the
//     next cycle; no further output until a new full frame arrives.
//  6. LOG_N=6, random complex data, 10 continuous frames -> output[k] == input[bitrev6(k)]
//     for every k; exactly 640 do_en cycles.

Source files
------------

// File: rtl/sdf_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed SDF FFT output to natural order.
// One bank fills at bitrev(wcnt) while the other drains at natural addresses.
module sdf_bitrev_reorder #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int N = 1 << LOG_N;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mem [2*N];
    logic [LOG_N-1:0]     wcnt, waddr;
    logic [LOG_N-1:0]     raddr, raddr_nxt;
    logic                 wbank, rbank;
    logic [1:0]           full, set_vec, clr_vec;
    logic                 wr_last, rd_issue, rd_last;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = v[LOG_N-1-i];
        end
        return r;
    endfunction

    // Write-side address and frame-complete / drain-complete events
    always_comb begin
        waddr   = bitrev(wcnt);
        wr_last = di_en && (&wcnt);
        set_vec = wr_last ? (2'b01 << wbank) : 2'b00;
        clr_vec = rd_last ? (2'b01 << rbank) : 2'b00;
    end

    // Write counter, fill bank and per-bank full flags
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            if (di_en) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last) begin
                    wbank <= ~wbank;
                end
            end
            full <= (full & ~clr_vec) | set_vec;
        end
    end

    // Sample storage; contents survive reset
    always_ff @(posedge clock) begin
        if (di_en) begin
            mem[{wbank, waddr}] <= {di_re, di_im};
        end
    end

    // Read FSM state, read address and drain bank
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            raddr <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_nxt;
            raddr <= raddr_nxt;
            if (rd_last) begin
                rbank <= ~rbank;
            end
        end
    end

    // Read FSM next state; chains straight into the other bank when it is ready
    always_comb begin
        state_nxt = state;
        raddr_nxt = raddr;
        rd_issue  = 1'b0;
        rd_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_nxt = READ;
                    raddr_nxt = '0;
                end
            end
            READ: begin
                rd_issue  = 1'b1;
                raddr_nxt = raddr + 1'b1;
                if (&raddr) begin
                    rd_last = 1'b1;
                    if (full[~rbank] || set_vec[~rbank]) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered RAM read straight into the output, valid aligned with data
    always_ff @(posedge clock) begin
        if (reset) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            do_en <= rd_issue;
            if (rd_issue) begin
                {do_re, do_im} <= mem[{rbank, raddr}];
            end
        end
    end

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Bench for sdf_bitrev_reorder: N=8 instance for directed cases, N=64 for random.
// A frame-level model predicts every output word and the cycle it must appear.
module tb_sdf_bitrev_reorder;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        en  [2];
    logic [15:0] re  [2];
    logic [15:0] im  [2];
    logic        oen [2];
    logic [15:0] ore [2];
    logic [15:0] oim [2];

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          last_end [2];
    int          ocnt [2];
    exp_t        expq [2][$];
    logic [31:0] frm [2][$];
    logic [31:0] cap [$];

    sdf_bitrev_reorder #(.LOG_N(3), .WIDTH(16)) dut8 (
        .clock(clock), .reset(reset),
        .di_en(en[0]), .di_re(re[0]), .di_im(im[0]),
        .do_en(oen[0]), .do_re(ore[0]), .do_im(oim[0])
    );

    sdf_bitrev_reorder #(.LOG_N(6), .WIDTH(16)) dut64 (
        .clock(clock), .reset(reset),
        .di_en(en[1]), .di_re(re[1]), .di_im(im[1]),
        .do_en(oen[1]), .do_re(ore[1]), .do_im(oim[1])
    );

    always #5 clock = ~clock;

    function automatic int brev(int v, int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: gather N samples, emit out[k] = in[bitrev(k)],
    // burst starts 2 edges after the last sample or right after the prior burst
    always @(posedge clock) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int lg;
            int n;
            lg = (d == 0) ? 3 : 6;
            n  = 1 << lg;
            if (reset) begin
                frm[d].delete();
                expq[d].delete();
                last_end[d] = cyc;
            end else if (en[d]) begin
                frm[d].push_back({re[d], im[d]});
                if (frm[d].size() == n) begin
                    int st;
                    st = cyc + 2;
                    if (st <= last_end[d]) st = last_end[d] + 1;
                    for (int k = 0; k < n; k++) begin
                        exp_t e;
                        e.cyc = st + k;
                        e.d   = frm[d][brev(k, lg)];
                        expq[d].push_back(e);
                    end
                    last_end[d] = st + n - 1;
                    frm[d].delete();
                end
            end
        end
    end

    // Output monitor: do_en every cycle, data whenever a word is due
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            logic due;
            while (expq[d].size() > 0 && expq[d][0].cyc < cyc) begin
                chk("missing_out_cycle", 64'(cyc), 64'(expq[d][0].cyc));
                void'(expq[d].pop_front());
            end
            due = (expq[d].size() > 0) && (expq[d][0].cyc == cyc);
            if (cyc > 0) begin
                chk(d == 0 ? "do_en_n8" : "do_en_n64", 64'(oen[d]), 64'(due));
            end
            if (due && oen[d] === 1'b1) begin
                chk(d == 0 ? "data_n8" : "data_n64",
                    64'({ore[d], oim[d]}), 64'(expq[d][0].d));
            end
            if (due) void'(expq[d].pop_front());
            if (oen[d] === 1'b1) begin
                ocnt[d]++;
                if (d == 0) cap.push_back({ore[0], oim[0]});
            end
        end
    end

    task automatic drive(int d, logic e, logic [15:0] r, logic [15:0] i);
        @(negedge clock);
        en[d] = e;
        re[d] = r;
        im[d] = i;
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(0, 1'b0, 16'h0, 16'h0);
            en[1] = 1'b0;
        end
    endtask

    task automatic chk_order(string tag, int base);
        int ord [8];
        ord = '{0, 4, 2, 6, 1, 5, 3, 7};
        chk({tag, "_len"}, 64'(cap.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] got;
            got = (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF;
            chk(tag, 64'(got),
                64'({16'(base + ord[i]), 16'(100 + base + ord[i])}));
        end
        cap.delete();
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0;
            re[d] = '0;
            im[d] = '0;
            last_end[d] = 0;
            ocnt[d] = 0;
        end
        repeat (3) @(negedge clock);
        chk("reset_do_en", 64'(oen[0]), 64'd0);
        chk("reset_do_re", 64'(ore[0]), 64'd0);
        chk("reset_do_im", 64'(oim[0]), 64'd0);
        chk("reset_do_en64", 64'(oen[1]), 64'd0);
        reset = 1'b0;
        cap.delete();

        // 1: single continuous frame
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 16'(i), 16'(100 + i));
        idle(14);
        chk_order("t1_order", 0);

        // 2: three back-to-back frames
        ocnt[0] = 0;
        for (int i = 0; i < 24; i++) begin
            drive(0, 1'b1, 16'($urandom), 16'($urandom));
        end
        idle(30);
        chk("t2_do_en_count", 64'(ocnt[0]), 64'd24);
        cap.delete();

        // 3: one sample every other cycle
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 16'(i), 16'(100 + i));
            drive(0, 1'b0, 16'hFFFF, 16'hFFFF);
        end
        idle(14);
        chk_order("t3_order", 0);

        // 4: reset after a partial frame, then a fresh frame
        for (int i = 0; i < 5; i++) drive(0, 1'b1, 16'(50 + i), 16'(150 + i));
        drive(0, 1'b0, 16'h0, 16'h0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 16'(10 + i), 16'(110 + i));
        idle(14);
        chk_order("t4_order", 10);

        // 5: reset during the third cycle of a drain
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 16'(20 + i), 16'(120 + i));
        seen = 0;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            drive(0, 1'b0, 16'h0, 16'h0);
            if (oen[0] === 1'b1) seen++;
            if (seen == 3) reset = 1'b1;
        end
        chk("t5_third_do_en", 64'(seen), 64'd3);
        @(negedge clock);
        reset = 1'b0;
        chk("t5_do_en_after_rst", 64'(oen[0]), 64'd0);
        chk("t5_do_re_after_rst", 64'(ore[0]), 64'd0);
        chk("t5_do_im_after_rst", 64'(oim[0]), 64'd0);
        ocnt[0] = 0;
        idle(20);
        chk("t5_no_output", 64'(ocnt[0]), 64'd0);
        cap.delete();

        // 6: N=64, ten continuous random frames
        ocnt[1] = 0;
        for (int i = 0; i < 640; i++) begin
            drive(1, 1'b1, 16'($urandom), 16'($urandom));
        end
        idle(80);
        chk("t6_do_en_count", 64'(ocnt[1]), 64'd640);
        chk("pending_n8", 64'(expq[0].size()), 64'd0);
        chk("pending_n64", 64'(expq[1].size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
